pixel_stream_writer: RTL

PIXEL_STREAM_WRITER -- requirements
Module: pixel_stream_writer

---
 rtl/pixel_stream_writer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pixel_stream_writer.sv
// Writes a raster pixel stream into a double-buffered framebuffer one row at a time.
// Optional PIXEL_STREAM_WRITER_SOF_RESYNC_EN: s_sof mid-frame restarts the frame at row 0.
module pixel_stream_writer #(
  parameter int N_ROWS     = 64,
  parameter int N_COLS     = 64,
  parameter int BITDEPTH   = 24,
  localparam int LOG_N_ROWS = $clog2(N_ROWS),
  localparam int LOG_N_COLS = $clog2(N_COLS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BITDEPTH-1:0]   s_data,
  input  logic                  s_valid,
  input  logic                  s_sof,
  output logic                  s_ready,
  input  logic                  fbw_row_rdy,
  input  logic                  frame_rdy,
  output logic [LOG_N_ROWS-1:0] fbw_row_addr,
  output logic                  fbw_row_store,
  output logic                  fbw_row_swap,
  output logic [BITDEPTH-1:0]   fbw_data,
  output logic [LOG_N_COLS-1:0] fbw_col_addr,
  output logic                  fbw_wren,
  output logic                  frame_swap
);

  // state      | meaning
  // WAIT_ROW   | waiting for a free line buffer
  // FILL       | accepting pixels of the current row
  // STORE      | pulse fbw_row_store for the completed row
  // SWAP       | pulse fbw_row_swap, advance row
  // WAIT_FRAME | last row done, waiting for frame_rdy
  typedef enum logic [2:0] {
    WAIT_ROW,
    FILL,
    STORE,
    SWAP,
    WAIT_FRAME
  } state_t;

  localparam logic [LOG_N_ROWS-1:0] ROW_LAST = LOG_N_ROWS'(N_ROWS - 1);
  localparam logic [LOG_N_COLS-1:0] COL_LAST = LOG_N_COLS'(N_COLS - 1);

  state_t                  state, state_nxt;
  logic [LOG_N_ROWS-1:0]   row, row_nxt;
  logic [LOG_N_COLS-1:0]   col, col_nxt;
  logic                    wren_nxt, store_nxt, swap_nxt, fswap_nxt;
  logic [BITDEPTH-1:0]     data_nxt;
  logic [LOG_N_COLS-1:0]   col_addr_nxt;
  logic                    beat;

  assign s_ready      = (state == FILL);
  assign beat         = s_valid & s_ready;
  assign fbw_row_addr = row;

`ifndef PIXEL_STREAM_WRITER_SOF_RESYNC_EN
  logic unused_sof;
  assign unused_sof = s_sof;
`endif

  always_comb begin
    state_nxt    = state;
    row_nxt      = row;
    col_nxt      = col;
    wren_nxt     = 1'b0;
    store_nxt    = 1'b0;
    swap_nxt     = 1'b0;
    fswap_nxt    = 1'b0;
    data_nxt     = fbw_data;
    col_addr_nxt = fbw_col_addr;
    unique case (state)
      WAIT_ROW: begin
        if (fbw_row_rdy) state_nxt = FILL;
      end
      FILL: begin
        if (beat) begin
          wren_nxt     = 1'b1;
          data_nxt     = s_data;
          col_addr_nxt = col;
`ifdef PIXEL_STREAM_WRITER_SOF_RESYNC_EN
          // A stray start-of-frame drops the partial row and restarts at (0,0).
          if (s_sof && ((row != '0) || (col != '0))) begin
            row_nxt      = '0;
            col_addr_nxt = '0;
            if (COL_LAST == '0) begin
              col_nxt   = '0;
              state_nxt = STORE;
            end else begin
              col_nxt = LOG_N_COLS'(1);
            end
          end else
`endif
          if (col == COL_LAST) begin
            col_nxt   = '0;
            state_nxt = STORE;
          end else begin
            col_nxt = col + 1'b1;
          end
        end
      end
      STORE: begin
        store_nxt = 1'b1;
        state_nxt = SWAP;
      end
      SWAP: begin
        swap_nxt = 1'b1;
        if (row == ROW_LAST) begin
          row_nxt   = '0;
          state_nxt = WAIT_FRAME;
        end else begin
          row_nxt   = row + 1'b1;
          state_nxt = WAIT_ROW;
        end
      end
      WAIT_FRAME: begin
        if (frame_rdy) begin
          fswap_nxt = 1'b1;
          state_nxt = WAIT_ROW;
        end
      end
      default: state_nxt = WAIT_ROW;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= WAIT_ROW;
      row           <= '0;
      col           <= '0;
      fbw_wren      <= 1'b0;
      fbw_row_store <= 1'b0;
      fbw_row_swap  <= 1'b0;
      frame_swap    <= 1'b0;
      fbw_data      <= '0;
      fbw_col_addr  <= '0;
    end else begin
      state         <= state_nxt;
      row           <= row_nxt;
      col           <= col_nxt;
      fbw_wren      <= wren_nxt;
      fbw_row_store <= store_nxt;
      fbw_row_swap  <= swap_nxt;
      frame_swap    <= fswap_nxt;
      fbw_data      <= data_nxt;
      fbw_col_addr  <= col_addr_nxt;
    end
  end

endmodule
